// File: rtl/ttm4_pkg.sv
// Shared encodings and constants for the SP stack sequencer.
package ttm4_pkg;

  typedef enum logic [2:0] {
    IDLE,
    P_SETUP,
    P_WRITE,
    P_STEP,
    Q_SETUP,
    Q_STEP,
    Q_READ,
    DONE
  } state_t;

  localparam int STACK_DEPTH = 256;
  localparam logic [7:0] SP_RESET = 8'hFF;
  localparam int DATA_W = 4;

endpackage

// File: rtl/stack_seq.sv
// Push/pop strobe sequencer for the SP counter, stack SRAM and STOREBUS.
// Also tracks stack depth and raises sticky overflow/underflow flags.
module stack_seq
  import ttm4_pkg::*;
#(
  parameter int DW    = 4,
  parameter int DEPTH = STACK_DEPTH,
  parameter int CNT_W = 9
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          PUSH_REQ,
  input  logic          POP_REQ,
  input  logic [DW-1:0] PUSH_DATA,
  input  logic          CLR_ERR,
  output logic          BUSY,
  output logic          ACK,
  output logic [DW-1:0] POP_DATA,
  output logic          OVF,
  output logic          UNF,
  output logic [CNT_W-1:0] LEVEL,
  output logic          nSK_EN,
  output logic          SP_D_nU,
  output logic          SPC,
  output logic [DW-1:0] STOREBUS_O,
  output logic          STOREBUS_OE,
  input  logic [DW-1:0] STOREBUS_I
);

  state_t state, state_n;

  logic [DW-1:0] data_q;
  logic          full;
  logic          empty;
  logic          push_acc;
  logic          pop_acc;
  logic          ovf_set;
  logic          unf_set;

  assign full     = (LEVEL == CNT_W'(DEPTH));
  assign empty    = (LEVEL == '0);
  assign push_acc = (state == IDLE) && PUSH_REQ;
  assign pop_acc  = (state == IDLE) && !PUSH_REQ && POP_REQ;
  assign ovf_set  = push_acc && full;
  assign unf_set  = pop_acc && empty;

  assign STOREBUS_O = data_q;

  always_comb begin
    state_n     = state;
    BUSY        = (state != IDLE);
    ACK         = 1'b0;
    nSK_EN      = 1'b1;
    SPC         = 1'b0;
    STOREBUS_OE = 1'b0;
    unique case (state)
      IDLE: begin
        if (PUSH_REQ)
          state_n = full ? DONE : P_SETUP;
        else if (POP_REQ)
          state_n = empty ? DONE : Q_SETUP;
      end
      P_SETUP: begin
        STOREBUS_OE = 1'b1;
        state_n     = P_WRITE;
      end
      P_WRITE: begin
        STOREBUS_OE = 1'b1;
        nSK_EN      = 1'b0;
        state_n     = P_STEP;
      end
      P_STEP: begin
        STOREBUS_OE = 1'b1;
        SPC         = 1'b1;
        state_n     = DONE;
      end
      Q_SETUP: state_n = Q_STEP;
      Q_STEP: begin
        SPC     = 1'b1;
        state_n = Q_READ;
      end
      Q_READ: begin
        nSK_EN  = 1'b0;
        state_n = DONE;
      end
      DONE: begin
        ACK     = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)
      state <= IDLE;
    else
      state <= state_n;
  end

  // Direction only moves on entry to a setup state, never beside SPC.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)
      SP_D_nU <= 1'b0;
    else if (state_n == P_SETUP)
      SP_D_nU <= 1'b1;
    else if (state_n == Q_SETUP)
      SP_D_nU <= 1'b0;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      data_q   <= '0;
      POP_DATA <= '0;
      LEVEL    <= '0;
    end else begin
      if (push_acc)
        data_q <= PUSH_DATA;
      if (state == Q_READ)
        POP_DATA <= STOREBUS_I;
      if (state == P_STEP)
        LEVEL <= LEVEL + 1'b1;
      else if (state == Q_STEP)
        LEVEL <= LEVEL - 1'b1;
    end
  end

  // A new error in the same cycle overrides the clear.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      OVF <= 1'b0;
      UNF <= 1'b0;
    end else begin
      OVF <= ovf_set | (OVF & ~CLR_ERR);
      UNF <= unf_set | (UNF & ~CLR_ERR);
    end
  end

endmodule

// File: tb/tb_stack_seq.sv
// Bench for stack_seq with a behavioural SP counter, stack SRAM and bus.
module tb_stack_seq;
  import ttm4_pkg::*;

  typedef struct {
    bit       push;
    bit       pop;
    logic [3:0] din;
    logic [3:0] exp_pop;
    int       exp_lvl;
    logic [7:0] exp_sp;
    bit       exp_ovf;
    bit       exp_unf;
    int       exp_spc;
    int       exp_lat;
  } vec_t;

  logic       CLK;
  logic       RST;
  logic       PUSH_REQ;
  logic       POP_REQ;
  logic [3:0] PUSH_DATA;
  logic       CLR_ERR;
  logic       BUSY;
  logic       ACK;
  logic [3:0] POP_DATA;
  logic       OVF;
  logic       UNF;
  logic [8:0] LEVEL;
  logic       nSK_EN;
  logic       SP_D_nU;
  logic       SPC;
  logic [3:0] STOREBUS_O;
  logic       STOREBUS_OE;
  logic [3:0] STOREBUS_I;

  logic [7:0] sp;
  logic [3:0] sram [256];
  logic       rd_en;
  logic [3:0] bus;

  int checks = 0;
  int errors = 0;
  int spc_cnt = 0;
  bit fight = 0;
  vec_t sb[$];
  vec_t tbl[9];

  stack_seq dut (
    .CLK(CLK), .RST(RST),
    .PUSH_REQ(PUSH_REQ), .POP_REQ(POP_REQ),
    .PUSH_DATA(PUSH_DATA), .CLR_ERR(CLR_ERR),
    .BUSY(BUSY), .ACK(ACK), .POP_DATA(POP_DATA),
    .OVF(OVF), .UNF(UNF), .LEVEL(LEVEL),
    .nSK_EN(nSK_EN), .SP_D_nU(SP_D_nU), .SPC(SPC),
    .STOREBUS_O(STOREBUS_O), .STOREBUS_OE(STOREBUS_OE),
    .STOREBUS_I(STOREBUS_I)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // SP block: write at SP, step on SPC, read at SP.
  assign rd_en = !nSK_EN && !SP_D_nU;
  assign STOREBUS_I = rd_en ? sram[sp] : 4'h0;
  assign bus = STOREBUS_OE ? STOREBUS_O : STOREBUS_I;

  always @(posedge CLK or negedge RST) begin
    if (!RST)
      sp <= SP_RESET;
    else if (SPC)
      sp <= SP_D_nU ? sp - 8'd1 : sp + 8'd1;
  end

  always @(posedge CLK) begin
    if (RST && !nSK_EN && SP_D_nU)
      sram[sp] <= bus;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: compare the oldest expected record on every ACK.
  always @(negedge CLK) begin
    vec_t e;
    if (STOREBUS_OE && rd_en)
      fight = 1'b1;
    if (!RST) begin
      spc_cnt = 0;
    end else begin
      if (SPC)
        spc_cnt++;
      if (ACK) begin
        if (sb.size() == 0) begin
          chk("sb_empty", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("pop_data", int'(POP_DATA), int'(e.exp_pop));
          chk("level", int'(LEVEL), e.exp_lvl);
          chk("sp", int'(sp), int'(e.exp_sp));
          chk("ovf", int'(OVF), int'(e.exp_ovf));
          chk("unf", int'(UNF), int'(e.exp_unf));
          chk("spc_pulses", spc_cnt, e.exp_spc);
          chk("no_fight", int'(fight), 0);
          if (e.push && !e.exp_ovf)
            chk("sram_wr", int'(sram[e.exp_sp + 8'd1]), int'(e.din));
        end
        spc_cnt = 0;
      end
    end
  end

  task automatic issue(input vec_t v);
    int lat;
    @(negedge CLK);
    PUSH_REQ  = v.push;
    POP_REQ   = v.pop;
    PUSH_DATA = v.din;
    sb.push_back(v);
    lat = 0;
    do begin
      @(negedge CLK);
      lat++;
      PUSH_REQ = 1'b0;
      POP_REQ  = 1'b0;
      if (lat == 1)
        chk("busy_rise", int'(BUSY), 1);
    end while (!ACK && lat < 20);
    chk("ack_latency", lat, v.exp_lat);
  endtask

  task automatic check_reset();
    chk("rst_busy", int'(BUSY), 0);
    chk("rst_ack", int'(ACK), 0);
    chk("rst_ovf", int'(OVF), 0);
    chk("rst_unf", int'(UNF), 0);
    chk("rst_level", int'(LEVEL), 0);
    chk("rst_popdata", int'(POP_DATA), 0);
    chk("rst_nsk", int'(nSK_EN), 1);
    chk("rst_dir", int'(SP_D_nU), 0);
    chk("rst_spc", int'(SPC), 0);
    chk("rst_oe", int'(STOREBUS_OE), 0);
    chk("rst_bus_o", int'(STOREBUS_O), 0);
    chk("rst_sp", int'(sp), 8'hFF);
  endtask

  function automatic vec_t mk(bit pu, bit po, logic [3:0] d,
                              logic [3:0] pd, int lv, bit ov, bit un);
    vec_t v;
    v.push = pu; v.pop = po; v.din = d; v.exp_pop = pd;
    v.exp_lvl = lv; v.exp_sp = 8'(255 - lv);
    v.exp_ovf = ov; v.exp_unf = un;
    v.exp_spc = (ov || un) ? 0 : 1;
    v.exp_lat = (ov || un) ? 1 : 4;
    return v;
  endfunction

  initial begin
    vec_t v;
    tbl[0] = mk(1, 0, 4'hA, 4'h0, 1, 0, 0);
    tbl[1] = mk(0, 1, 4'h0, 4'hA, 0, 0, 0);
    tbl[2] = mk(1, 0, 4'h3, 4'hA, 1, 0, 0);
    tbl[3] = mk(1, 0, 4'h5, 4'hA, 2, 0, 0);
    tbl[4] = mk(1, 0, 4'h9, 4'hA, 3, 0, 0);
    tbl[5] = mk(0, 1, 4'h0, 4'h9, 2, 0, 0);
    tbl[6] = mk(0, 1, 4'h0, 4'h5, 1, 0, 0);
    tbl[7] = mk(0, 1, 4'h0, 4'h3, 0, 0, 0);
    tbl[8] = mk(0, 1, 4'h0, 4'h3, 0, 0, 1);

    RST = 1'b0; PUSH_REQ = 1'b0; POP_REQ = 1'b0;
    PUSH_DATA = 4'h0; CLR_ERR = 1'b0;
    repeat (2) @(negedge CLK);
    check_reset();
    RST = 1'b1;

    for (int i = 0; i < 9; i++)
      issue(tbl[i]);

    @(negedge CLK);
    CLR_ERR = 1'b1;
    @(negedge CLK);
    CLR_ERR = 1'b0;
    chk("clr_unf", int'(UNF), 0);

    for (int i = 0; i < 256; i++)
      issue(mk(1, 0, 4'(i), 4'h3, i + 1, 0, 0));
    v = mk(1, 0, 4'hF, 4'h3, 256, 1, 0);
    v.exp_sp = 8'hFF;
    issue(v);
    chk("ovf_no_write", int'(sram[8'hFF]), 0);

    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    check_reset();
    RST = 1'b1;

    issue(mk(1, 1, 4'h6, 4'h0, 1, 0, 0));

    @(negedge CLK);
    PUSH_REQ = 1'b1;
    PUSH_DATA = 4'hC;
    @(negedge CLK);
    PUSH_REQ = 1'b0;
    @(negedge CLK);
    chk("mid_pwrite_nsk", int'(nSK_EN), 0);
    RST = 1'b0;
    #1;
    check_reset();
    @(negedge CLK);
    RST = 1'b1;
    chk("sb_drained", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
